// File: rtl/bram_access_arbiter_pkg.sv
// bram_access_arbiter_pkg: shared state encoding, read latency and client ids
package bram_access_arbiter_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY} state_t;
  localparam int RD_LAT = 1;
  localparam logic CL_R0 = 1'b0;
  localparam logic CL_CUR = 1'b1;
endpackage

// File: rtl/bram_access_arbiter_if.sv
// bram_access_arbiter_if: R0 random-access read handshake
interface bram_access_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic ack;
  logic [7:0] rdata;
  logic oor;
  modport master(output req, addr, input ack, rdata, oor);
  modport slave(input req, addr, output ack, rdata, oor);
endinterface

// File: rtl/bram_access_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the last-granted client loses a tie
module rr_arb2
  import bram_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt[CL_R0] = req[CL_R0] && (!req[CL_CUR] || last == CL_CUR);
  assign gnt[CL_CUR] = req[CL_CUR] && (!req[CL_R0] || last == CL_R0);
  always_ff @(posedge clk) begin
    if (reset) last <= CL_CUR;
    else if (|gnt) last <= gnt[CL_CUR];
  end
endmodule

// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: sequences the SD byte buffer through fill and shares its read port
module bram_access_arbiter
  import bram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  input  logic                  load_done,
  bram_access_arbiter_if.slave  r0,
  input  logic                  step,
  output logic [ADDR_W-1:0]     cur_addr,
  output logic [7:0]            cur_data,
  output logic                  cur_valid,
  output logic                  bram_we,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [7:0]            bram_din,
  input  logic [7:0]            bram_dout,
  output logic [ADDR_W:0]       fill_count,
  output logic                  ready,
  output logic                  overflow
);
  state_t state, state_n;
  logic step_q, step_rise, full, wr_ok, adv, entry, r0_oor_now, r0_oor_q, cur_pend;
  logic [1:0] req, gnt;
  logic [RD_LAT-1:0] r0_sh, cur_sh;
  logic [ADDR_W:0] cur_inc;
  assign ready = state == ST_READY;
  assign full = fill_count == (ADDR_W+1)'(DEPTH);
  assign wr_ok = wr_valid && !ready && !full;
  assign step_rise = step && !step_q;
  assign adv = ready && step_rise && fill_count != '0;
  assign r0_oor_now = {1'b0, r0.addr} >= fill_count;
  assign cur_inc = {1'b0, cur_addr} + 1'b1;
  // R0 stays blocked from grant until its ack has gone out
  assign req[CL_R0] = ready && r0.req && !(|r0_sh) && !r0.ack;
  assign req[CL_CUR] = ready && cur_pend;
  rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt)
  );
  always_comb begin
    state_n = (state == ST_EMPTY && wr_valid) ? ST_LOAD
            : (state != ST_READY && load_done && !wr_valid) ? ST_READY : state;
    entry = state_n == ST_READY && !ready;
    bram_we = wr_ok;
    bram_din = wr_ok ? wr_data : 8'h00;
    bram_addr = wr_ok ? fill_count[ADDR_W-1:0]
              : (gnt[CL_R0] && !r0_oor_now) ? r0.addr
              : gnt[CL_CUR] ? cur_addr : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      fill_count <= '0;
      overflow <= 1'b0;
      step_q <= 1'b0;
      r0_sh <= '0;
      r0_oor_q <= 1'b0;
      r0.ack <= 1'b0;
      r0.rdata <= 8'h00;
      r0.oor <= 1'b0;
      cur_sh <= '0;
      cur_pend <= 1'b0;
      cur_addr <= '0;
      cur_data <= 8'h00;
      cur_valid <= 1'b0;
    end else begin
      state <= state_n;
      step_q <= step;
      if (wr_ok) fill_count <= fill_count + 1'b1;
      if (wr_valid && (ready || full)) overflow <= 1'b1;
      r0_sh <= RD_LAT'(r0_sh << 1) | RD_LAT'(gnt[CL_R0]);
      if (gnt[CL_R0]) r0_oor_q <= r0_oor_now;
      r0.ack <= r0_sh[RD_LAT-1];
      if (r0_sh[RD_LAT-1]) begin
        r0.rdata <= r0_oor_q ? 8'h00 : bram_dout;
        r0.oor <= r0_oor_q;
      end
      // a cursor move flushes any fetch still in flight for the old address
      cur_sh <= adv ? '0 : RD_LAT'(cur_sh << 1) | RD_LAT'(gnt[CL_CUR]);
      if (entry) begin
        cur_addr <= '0;
        cur_data <= 8'h00;
        cur_pend <= fill_count != '0;
        cur_valid <= fill_count == '0;
      end else if (adv) begin
        cur_addr <= cur_inc == fill_count ? '0 : cur_inc[ADDR_W-1:0];
        cur_valid <= 1'b0;
        cur_pend <= 1'b1;
      end else begin
        if (gnt[CL_CUR]) cur_pend <= 1'b0;
        if (cur_sh[RD_LAT-1]) begin
          cur_data <= bram_dout;
          cur_valid <= 1'b1;
        end
      end
    end
  end
endmodule
